// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and the queue entry type for the fetch stage.
package fetch_unit_pkg;

  localparam int ADDR_W    = 32;
  localparam int INSTR_W   = 32;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;

  localparam logic [ADDR_W-1:0]  PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode.
// Flush empties the queue; a pop in the same cycle is simply absorbed by it.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(BUF_DEPTH);

  fetch_entry_t     mem_q [BUF_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from before this edge.
    if (!rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage is reset too, because decode must see out_pc/out_instr = 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '{pc: '0, instr: NOP};
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst) !(do_push && count_q == FULL_C)
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues to a registered-read instruction memory
// and queues returned words for decode; a redirect squashes everything fetched so far.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                INS_MEM_SIZE = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              in_flight_q, in_flight_d;
  logic              pop, push, issue;
  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W:0]    credit_used;
  fetch_entry_t      push_entry, head_entry;

  assign pop = out_valid & out_ready;

  // Queued + in-flight words after this cycle's pop; a new fetch needs a free slot to land in.
  assign credit_used = {1'b0, buf_count}
                     + {{CNT_W{1'b0}}, in_flight_q}
                     - {{CNT_W{1'b0}}, pop};
  assign issue = fetch_en & ~redirect_valid & (credit_used < DEPTH_C);

  // The word returning this cycle is wrong-path if a redirect arrives alongside it.
  assign push       = in_flight_q & ~redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: imem_instr};

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    in_flight_d = issue;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      in_flight_q <= in_flight_d;
    end
  end

  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .valid_o (out_valid),
    .count_o (buf_count),
    .head_o  (head_entry)
  );

  assign imem_pc   = pc_q;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

`ifndef SYNTHESIS
  // Out-of-range PCs alias in the memory; flag the first one so software bugs are visible.
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(INS_MEM_SIZE) << 2;
  logic oob_warned_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      oob_warned_q <= 1'b0;
    end else if (issue && ({1'b0, pc_q} >= MEM_BYTES) && !oob_warned_q) begin
      oob_warned_q <= 1'b1;
      $warning("fetch_unit: pc %h beyond instruction memory, address aliases", pc_q);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a program-order stream model checks every word decode
// accepts, plus directed timing checks for reset, back-pressure, redirect and PC wrap.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MEM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic [31:0] mem [MEM_WORDS];

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state: the next PC decode should receive, in program order.
  logic [31:0] exp_pc;
  bit          hold;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  int          stall;

  fetch_unit #(
    .RESET_PC     (RESET_PC),
    .INS_MEM_SIZE (MEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory, aliased on pc[13:2].
  always @(posedge clk) imem_instr <= mem[imem_pc[13:2]];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, then score what decode sees this cycle.
  task automatic step(input logic r, input logic en, input logic rdy,
                      input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst            = r;
    fetch_en       = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (!r) begin
      exp_pc = RESET_PC;
      hold   = 1'b0;
      stall  = 0;
    end else begin
      if (hold) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_pc",    {32'd0, out_pc},    {32'd0, hold_pc});
        check("hold_instr", {32'd0, out_instr}, {32'd0, hold_instr});
      end
      hold       = out_valid && !rdy && !rv;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      check("imem_align", {62'd0, imem_pc[1:0]}, 64'd0);
      if (out_valid && rdy) begin
        check("pop_pc",    {32'd0, out_pc},    {32'd0, exp_pc});
        check("pop_instr", {32'd0, out_instr}, {32'd0, mem[exp_pc[13:2]]});
        exp_pc = exp_pc + 32'd4;
        stall  = 0;
      end else if (en && rdy && !rv) begin
        stall++;
        check("liveness", {63'd0, (stall < 3)}, 64'd1);
      end else begin
        stall = 0;
      end
      if (rv) begin
        exp_pc = {rpc[31:2], 2'b00};
        stall  = 0;
      end
    end
  endtask

  logic [31:0] frozen_pc;
  logic [31:0] rnd_pc;
  int          sel;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    rst = 1'b0; fetch_en = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    exp_pc = RESET_PC; hold = 1'b0; stall = 0;

    // Reset state
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_valid",   {63'd0, out_valid}, 64'd0);
    check("rst_out_pc",  {32'd0, out_pc},    64'd0);
    check("rst_instr",   {32'd0, out_instr}, 64'd0);
    check("rst_imem_pc", {32'd0, imem_pc},   {32'd0, RESET_PC});

    // Release: C0 fetches RESET_PC, first word visible in C2, then one per cycle
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("c0_imem_pc", {32'd0, imem_pc},   {32'd0, RESET_PC});
    check("c0_valid",   {63'd0, out_valid}, 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("c1_valid",   {63'd0, out_valid}, 64'd0);
    check("c1_imem_pc", {32'd0, imem_pc},   {32'd0, RESET_PC + 32'd4});
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_pc",    {32'd0, out_pc},    {32'd0, RESET_PC + 32'(4 * k)});
    end

    // Back-pressure for 5 cycles: fetch address freezes, head held
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    frozen_pc = imem_pc;
    repeat (4) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("bp_imem_pc", {32'd0, imem_pc}, {32'd0, frozen_pc});
    end
    repeat (4) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check("bp_drain_valid", {63'd0, out_valid}, 64'd1);
    end

    // Redirect with words queued and one in flight; target misaligned
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0043);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rd_valid_n1", {63'd0, out_valid}, 64'd0);
    check("rd_imem_pc",  {32'd0, imem_pc},   64'h40);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rd_valid_n2", {63'd0, out_valid}, 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rd_valid_n3", {63'd0, out_valid}, 64'd1);
    check("rd_out_pc",   {32'd0, out_pc},    64'h40);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect in the same cycle as an accepted pop; fetching paused afterwards
    check("rp_head_valid", {63'd0, out_valid}, 64'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("rp_empty_1", {63'd0, out_valid}, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("rp_empty_2", {63'd0, out_valid}, 64'd0);
    repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_pc0", {32'd0, out_pc}, 64'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_pc1", {32'd0, out_pc}, 64'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_pc2", {32'd0, out_pc}, 64'h0000_0000);

    // Reset with the queue full
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("mid_rst_valid",   {63'd0, out_valid}, 64'd0);
    check("mid_rst_imem_pc", {32'd0, imem_pc},   {32'd0, RESET_PC});
    check("mid_rst_out_pc",  {32'd0, out_pc},    64'd0);

    // Random traffic against the stream model
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      rnd_pc = $urandom;
      else if (sel == 1) rnd_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else               rnd_pc = $urandom & 32'h3FFF;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 7,    $urandom_range(0, 19) == 0, rnd_pc);
    end
    repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("final_drained", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
